// File: rtl/pattern_gen_if.sv
// Video link between the sync generator and the pattern generator: SG_* timing in, DSP_* pixels out.
// The master modport is the sync-generator side; the slave modport is the pattern generator.
interface pattern_gen_if;
  logic       VRSTART;
  logic       SG_HSYNC_X;
  logic       SG_VSYNC_X;
  logic       SG_preDE;
  logic       DSP_HSYNC_X;
  logic       DSP_VSYNC_X;
  logic       DSP_DE;
  logic [7:0] DSP_R;
  logic [7:0] DSP_G;
  logic [7:0] DSP_B;

  modport master (
    output VRSTART, SG_HSYNC_X, SG_VSYNC_X, SG_preDE,
    input  DSP_HSYNC_X, DSP_VSYNC_X, DSP_DE, DSP_R, DSP_G, DSP_B
  );

  modport slave (
    input  VRSTART, SG_HSYNC_X, SG_VSYNC_X, SG_preDE,
    output DSP_HSYNC_X, DSP_VSYNC_X, DSP_DE, DSP_R, DSP_G, DSP_B
  );
endinterface

// File: rtl/pattern_gen.sv
// Test-pattern generator: colour bars, gray ramp, checkerboard, bouncing box, auto-cycle; 1-cycle registered output.
// Optional white frame border around the active area when PATTERN_BORDER_EN is defined.
module pattern_gen #(
  parameter int BOX_SIZE    = 64,
  parameter int BOX_STEP    = 4,
  parameter int AUTO_FRAMES = 120,
  parameter int CHK_LOG2    = 5
) (
  input  logic       DCLK,
  input  logic       DRST_X,
  input  logic [1:0] RESOL,
  input  logic [2:0] PSEL,
  pattern_gen_if.slave vid
);

  typedef enum logic { INC, DEC } dir_t;

  typedef struct packed {
    logic [10:0] pos;
    dir_t        dir;
  } axis_t;

  localparam logic [10:0] SIZE      = 11'(BOX_SIZE);
  localparam logic [10:0] STEP      = 11'(BOX_STEP);
  localparam logic [7:0]  AUTO_LAST = 8'(AUTO_FRAMES - 1);

  function automatic logic [10:0] res_w(input logic [1:0] r);
    case (r)
      2'd0:    return 11'd640;
      2'd1:    return 11'd800;
      2'd2:    return 11'd1024;
      default: return 11'd1280;
    endcase
  endfunction

  function automatic logic [10:0] res_h(input logic [1:0] r);
    case (r)
      2'd0:    return 11'd480;
      2'd1:    return 11'd600;
      2'd2:    return 11'd768;
      default: return 11'd1024;
    endcase
  endfunction

  function automatic logic [7:0] res_bw(input logic [1:0] r);
    case (r)
      2'd0:    return 8'd80;
      2'd1:    return 8'd100;
      2'd2:    return 8'd128;
      default: return 8'd160;
    endcase
  endfunction

  // One bounce step per frame; a position past a shrunken limit snaps to it and heads back.
  function automatic axis_t step_axis(input axis_t a, input logic [10:0] lim);
    axis_t n;
    n = a;
    if (a.pos > lim) begin
      n.pos = lim;
      n.dir = DEC;
    end else if (a.dir == INC) begin
      if ({1'b0, a.pos} + {1'b0, STEP} > {1'b0, lim}) begin
        n.pos = lim;
        n.dir = DEC;
      end else begin
        n.pos = a.pos + STEP;
      end
    end else begin
      if (a.pos < STEP) begin
        n.pos = '0;
        n.dir = INC;
      end else begin
        n.pos = a.pos - STEP;
      end
    end
    return n;
  endfunction

  logic        vr_d, pre_d, active;
  logic [1:0]  res_q, pat;
  logic [7:0]  fcnt;
  logic [10:0] xcnt, ycnt;
  axis_t       bx, by;
  logic        fs, line_end, draw;
  logic [2:0]  bar;
  logic        in_x, in_y;
  logic [23:0] pix;

  assign fs       = vid.VRSTART & ~vr_d;
  assign line_end = pre_d & ~vid.SG_preDE;
  assign draw     = vid.SG_preDE & (active | fs);

  // NOTE: every variable gets a default at the top of an always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    pix  = '0;
    bar  = '0;
    in_x = (xcnt >= bx.pos) && ({1'b0, xcnt} < {1'b0, bx.pos} + 12'(BOX_SIZE));
    in_y = (ycnt >= by.pos) && ({1'b0, ycnt} < {1'b0, by.pos} + 12'(BOX_SIZE));
    case (pat)
      2'd0: begin
        for (int k = 1; k < 8; k++)
          if (xcnt >= 11'(k) * {3'b000, res_bw(res_q)}) bar = bar + 3'd1;
        // Bar order white..black maps onto inverted index bits.
        pix = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
      end
      2'd1:    pix = {3{xcnt[7:0]}};
      2'd2:    pix = (xcnt[CHK_LOG2] ^ ycnt[CHK_LOG2]) ? 24'hFFFFFF : 24'h000000;
      default: pix = (in_x && in_y) ? 24'hFFFFFF : 24'h0000FF;
    endcase
`ifdef PATTERN_BORDER_EN
    if (xcnt == 11'd0 || xcnt == res_w(res_q) - 11'd1 ||
        ycnt == 11'd0 || ycnt == res_h(res_q) - 11'd1)
      pix = 24'hFFFFFF;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge DCLK) begin
    // NOTE: reset is synchronous; DRST_X is only looked at on a DCLK edge.
    if (!DRST_X) begin
      vr_d            <= 1'b0;
      pre_d           <= 1'b0;
      active          <= 1'b0;
      res_q           <= 2'd0;
      pat             <= 2'd0;
      fcnt            <= 8'd0;
      xcnt            <= 11'd0;
      ycnt            <= 11'd0;
      bx              <= '{pos: 11'd0, dir: INC};
      by              <= '{pos: 11'd0, dir: INC};
      vid.DSP_HSYNC_X <= 1'b1;
      vid.DSP_VSYNC_X <= 1'b1;
      vid.DSP_DE      <= 1'b0;
      {vid.DSP_R, vid.DSP_G, vid.DSP_B} <= 24'h0;
    end else begin
      vr_d            <= vid.VRSTART;
      pre_d           <= vid.SG_preDE;
      vid.DSP_HSYNC_X <= vid.SG_HSYNC_X;
      vid.DSP_VSYNC_X <= vid.SG_VSYNC_X;
      vid.DSP_DE      <= draw;
      {vid.DSP_R, vid.DSP_G, vid.DSP_B} <= draw ? pix : 24'h0;
      xcnt            <= vid.SG_preDE ? xcnt + 11'd1 : 11'd0;

      if (fs) begin
        active <= 1'b1;
        res_q  <= RESOL;
        ycnt   <= 11'd0;
        bx     <= step_axis(bx, res_w(RESOL) - SIZE);
        by     <= step_axis(by, res_h(RESOL) - SIZE);
        if (PSEL[2]) begin
          if (fcnt == AUTO_LAST) begin
            fcnt <= 8'd0;
            pat  <= pat + 2'd1;
          end else begin
            fcnt <= fcnt + 8'd1;
          end
        end else begin
          fcnt <= 8'd0;
          pat  <= PSEL[1:0];
        end
      end else if (line_end && ycnt < res_h(res_q) - 11'd1) begin
        ycnt <= ycnt + 11'd1;
      end
    end
  end

endmodule

// File: tb/tb_pattern_gen.sv
// Scoreboard bench for pattern_gen: the line driver queues expected outputs, a negedge monitor pops and compares.
// Expectations account for PATTERN_BORDER_EN when the bench is built with it.
module tb_pattern_gen;

  logic       DCLK = 1'b0;
  logic       DRST_X;
  logic [1:0] RESOL;
  logic [2:0] PSEL;

  pattern_gen_if vid ();

  pattern_gen #(
    .BOX_SIZE   (64),
    .BOX_STEP   (4),
    .AUTO_FRAMES(3),
    .CHK_LOG2   (5)
  ) dut (
    .DCLK  (DCLK),
    .DRST_X(DRST_X),
    .RESOL (RESOL),
    .PSEL  (PSEL),
    .vid   (vid)
  );

  always #5 DCLK = ~DCLK;

`ifdef PATTERN_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
  } exp_t;

  exp_t        exp_q[$];
  string       nm_q[$];
  int          w_x[$];
  int          w_y[$];
  bit          w_de[$];
  logic [23:0] w_rgb[$];
  string       w_nm[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit mark = 1'b0;
  bit mark_d = 1'b0;
  int psel_line = -1;
  logic [2:0] psel_new = 3'd0;

  task automatic check(input string nm, input exp_t got, input exp_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got de=%b hs=%b vs=%b rgb=%06h, expected de=%b hs=%b vs=%b rgb=%06h",
               nm, got.de, got.hs, got.vs, got.rgb, want.de, want.hs, want.vs, want.rgb);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  // Monitor: one queued expectation per marked input cycle, compared one cycle later.
  always @(posedge DCLK) mark_d <= mark;

  always @(negedge DCLK) begin
    exp_t got, e;
    string nm;
    if (mark_d) begin
      got = {vid.DSP_DE, vid.DSP_HSYNC_X, vid.DSP_VSYNC_X, vid.DSP_R, vid.DSP_G, vid.DSP_B};
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_underflow: output marked with no expectation queued");
      end else begin
        e  = exp_q.pop_front();
        nm = nm_q.pop_front();
        check(nm, got, e);
      end
    end
  end

  function automatic int rw(input logic [1:0] r);
    case (r)
      2'd0:    return 640;
      2'd1:    return 800;
      2'd2:    return 1024;
      default: return 1280;
    endcase
  endfunction

  function automatic int rh(input logic [1:0] r);
    case (r)
      2'd0:    return 480;
      2'd1:    return 600;
      2'd2:    return 768;
      default: return 1024;
    endcase
  endfunction

  task automatic want(input int x, input int y, input logic [23:0] rgb, input string nm);
    logic [23:0] c;
    c = rgb;
    if (BORDER && (x == 0 || x == rw(RESOL) - 1 || y == 0 || y == rh(RESOL) - 1)) c = 24'hFFFFFF;
    w_x.push_back(x); w_y.push_back(y); w_de.push_back(1'b1); w_rgb.push_back(c); w_nm.push_back(nm);
  endtask

  task automatic want_off(input int x, input int y, input string nm);
    w_x.push_back(x); w_y.push_back(y); w_de.push_back(1'b0); w_rgb.push_back(24'h0); w_nm.push_back(nm);
  endtask

  task automatic clear_wants();
    w_x.delete(); w_y.delete(); w_de.delete(); w_rgb.delete(); w_nm.delete();
  endtask

  function automatic int find(input int x, input int y);
    for (int i = 0; i < w_x.size(); i++)
      if (w_x[i] == x && w_y[i] == y) return i;
    return -1;
  endfunction

  function automatic int line_pix(input int y, input int minpix);
    int n;
    n = minpix;
    for (int i = 0; i < w_x.size(); i++)
      if (w_y[i] == y && w_de[i] && w_x[i] + 1 > n) n = w_x[i] + 1;
    return n;
  endfunction

  task automatic step(input bit pre, input bit hs, input bit vs, input bit vr,
                      input bit chk, input exp_t e, input string nm);
    vid.SG_preDE   = pre;
    vid.SG_HSYNC_X = hs;
    vid.SG_VSYNC_X = vs;
    vid.VRSTART    = vr;
    mark           = chk;
    if (chk) begin
      exp_q.push_back(e);
      nm_q.push_back(nm);
    end
    @(posedge DCLK);
    #1;
  endtask

  // Line: 4 blanking cycles (first two with hsync low), npix active cycles, 2 trailing blanking cycles.
  task automatic run_line(input int y, input int npix, input bit vs, input bit vr);
    for (int c = -4; c < npix + 2; c++) begin
      int   i;
      bit   hs;
      exp_t e;
      i  = find(c, y);
      hs = (c >= -2);
      e  = '0;
      if (i >= 0) e = {w_de[i], hs, vs, w_rgb[i]};
      step(c >= 0 && c < npix, hs, vs, vr, i >= 0, e, (i >= 0) ? w_nm[i] : "");
    end
  endtask

  task automatic run_frame(input int nlines, input int minpix);
    run_line(-2, 0, 1'b0, 1'b0);
    run_line(-1, 0, 1'b1, 1'b0);
    for (int y = 0; y < nlines; y++) begin
      if (y == psel_line) PSEL = psel_new;
      run_line(y, line_pix(y, minpix), 1'b1, y == 0);
    end
    clear_wants();
    psel_line = -1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          bk[9]  = '{1, 50, 104, 105, 106, 144, 145, 146, 150};
    int          bxs[9] = '{4, 200, 416, 420, 424, 576, 576, 572, 556};
    int          bys[9] = '{4, 200, 416, 416, 412, 260, 256, 252, 236};
    int          ap[12] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    logic [23:0] col[4] = '{24'hFFFF00, 24'h646464, 24'hFFFFFF, 24'h0000FF};
    int          j;

    DRST_X = 1'b0;
    RESOL  = 2'd0;
    PSEL   = 3'd0;
    vid.VRSTART = 1'b0; vid.SG_HSYNC_X = 1'b1; vid.SG_VSYNC_X = 1'b1; vid.SG_preDE = 1'b0;
    @(posedge DCLK);
    #1;

    // Reset with SG_* toggling: outputs pinned at idle values.
    for (int i = 0; i < 5; i++) begin
      bit b;
      b = (i % 2) == 0;
      step(b, ~b, ~b, b, 1'b1, {1'b0, 1'b1, 1'b1, 24'h0}, "reset_idle");
    end
    DRST_X = 1'b1;

    // No DE before the first frame start.
    want_off(5, 100, "pre_fs_de");
    want_off(19, 100, "pre_fs_de_end");
    run_line(100, 20, 1'b1, 1'b0);
    clear_wants();

    // Colour bars, 640 wide.
    want_off(0, -2, "vsync_delayed");
    want_off(-4, 0, "hsync_delayed");
    want_off(-1, 0, "bar_de_rise");
    want(0, 0, 24'hFFFFFF, "bar_x0");
    want(79, 0, 24'hFFFFFF, "bar_x79");
    want(80, 0, 24'hFFFF00, "bar_x80");
    want(639, 0, 24'h000000, "bar_x639");
    want_off(640, 0, "bar_de_fall");
    want(160, 1, 24'h00FFFF, "bar_cyan");
    want(240, 1, 24'h00FF00, "bar_green");
    want(320, 1, 24'hFF00FF, "bar_magenta");
    want(400, 1, 24'hFF0000, "bar_red");
    want(480, 1, 24'h0000FF, "bar_blue");
    want(560, 2, 24'h000000, "bar_black");
    run_frame(3, 640);

    // Bar widths at the other resolutions.
    RESOL = 2'd1;
    want(99, 1, 24'hFFFFFF, "bar800_x99");
    want(100, 1, 24'hFFFF00, "bar800_x100");
    run_frame(2, 1);
    RESOL = 2'd2;
    want(127, 1, 24'hFFFFFF, "bar1024_x127");
    want(128, 1, 24'hFFFF00, "bar1024_x128");
    run_frame(2, 1);
    RESOL = 2'd3;
    want(159, 1, 24'hFFFFFF, "bar1280_x159");
    want(160, 1, 24'hFFFF00, "bar1280_x160");
    want(1119, 1, 24'h0000FF, "bar1280_x1119");
    want(1120, 1, 24'h000000, "bar1280_x1120");
    run_frame(2, 1);

    // Checkerboard at 1024x768, with a mid-frame PSEL change that must not take effect.
    RESOL = 2'd2;
    PSEL  = 3'd2;
    want(31, 0, 24'h000000, "chk_31_0");
    want(32, 0, 24'hFFFFFF, "chk_32_0");
    want(32, 32, 24'h000000, "chk_32_32");
    want(1, 32, 24'hFFFFFF, "chk_1_32");
    psel_line = 1;
    psel_new  = 3'd1;
    run_frame(33, 1);

    // Gray ramp from the next frame on.
    want(300, 1, 24'h2C2C2C, "gray_x300");
    want(255, 1, 24'hFFFFFF, "gray_x255");
    want(256, 1, 24'h000000, "gray_x256");
    want(1, 1, 24'h010101, "gray_x1");
    run_frame(2, 1);

    // YCNT saturates at H-1 (bit 5 would flip if it kept counting past 479).
    RESOL = 2'd0;
    PSEL  = 3'd2;
    want(1, 31, 24'h000000, "ysat_y31");
    want(1, 32, 24'hFFFFFF, "ysat_y32");
    want(1, 479, 24'h000000, "ysat_y479");
    want(1, 482, 24'h000000, "ysat_hold");
    run_frame(483, 1);

    // Box bounce from a fresh reset at 640x480.
    DRST_X = 1'b0;
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, {1'b0, 1'b1, 1'b1, 24'h0}, "reset2_idle");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, "");
    DRST_X = 1'b1;
    PSEL   = 3'd3;
    j = 0;
    for (int k = 1; k <= 150; k++) begin
      if (j < 9 && bk[j] == k) begin
        want(bxs[j], bys[j], 24'hFFFFFF, $sformatf("box_in_f%0d", k));
        want(bxs[j] + 64, bys[j], 24'h0000FF, $sformatf("box_right_f%0d", k));
        want(bxs[j] - 1, bys[j], 24'h0000FF, $sformatf("box_left_f%0d", k));
        want(bxs[j], bys[j] - 1, 24'h0000FF, $sformatf("box_above_f%0d", k));
        run_frame(bys[j] + 1, 1);
        j++;
      end else begin
        run_frame(1, 1);
      end
    end

    // Auto-cycle, entered from pattern 0; box sits well below row 2 during these frames.
    PSEL = 3'd0;
    want(100, 1, 24'hFFFF00, "manual_bar");
    run_frame(2, 1);
    PSEL = 3'd4;
    for (int i = 0; i < 12; i++) begin
      want(100, 1, col[ap[i]], $sformatf("auto_f%0d_l1", i + 1));
      want(100, 2, col[ap[i]], $sformatf("auto_f%0d_l2", i + 1));
      run_frame(3, 1);
    end

    // 800x600 box frame; box now at (500,180), edges white only with the border option.
    RESOL = 2'd1;
    PSEL  = 3'd3;
    want(0, 300, 24'h0000FF, "edge_0_300");
    want(799, 10, 24'h0000FF, "edge_799_10");
    want(400, 0, 24'h0000FF, "edge_400_0");
    want(400, 599, 24'h0000FF, "edge_400_599");
    want(400, 300, 24'h0000FF, "inner_400_300");
    want(500, 180, 24'hFFFFFF, "box800_corner");
    run_frame(600, 1);

    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, "");
    check_int("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
